// File: rtl/rv32_pkg.sv
// Shared types for the rv32imc_ss multiply/divide unit.
package rv32_pkg;

  // funct3 encodings of the RV32M operations.
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } muldiv_state_e;

  localparam logic [31:0] IntMin  = 32'h8000_0000;
  localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;

endpackage

// File: rtl/rv32_mod_muldiv_step.sv
// One iteration of the shared shift-add / restoring-divide datapath.
// Multiply consumes multiplier bits MSB first: acc = 2*acc + bit*b.
// Divide shifts the next dividend bit into the partial remainder and
// trial-subtracts the divisor.
module rv32_mod_muldiv_step
  import rv32_pkg::*;
(
  input  logic        is_div_i,
  input  logic [63:0] acc_i,
  input  logic        bit_i,
  input  logic [31:0] opb_i,
  output logic [63:0] acc_o,
  output logic        qbit_o
);

  logic [32:0] shifted;
  logic [33:0] diff;

  // Single combinational step for either mode.
  always_comb begin
    shifted = {acc_i[31:0], bit_i};
    diff    = {1'b0, shifted} - {2'b00, opb_i};
    qbit_o  = 1'b0;
    acc_o   = '0;
    if (is_div_i) begin
      // Non-negative difference means the divisor fits: keep it, quotient bit 1.
      qbit_o = ~diff[33];
      acc_o  = {31'b0, (diff[33] ? shifted : diff[32:0])};
    end else begin
      acc_o = {acc_i[62:0], 1'b0} + (bit_i ? {32'b0, opb_i} : 64'b0);
    end
  end

endmodule

// File: rtl/rv32_mod_muldiv.sv
// Iterative RV32M multiply/divide unit: FSM, iteration counter, sign fixup
// and special-case detection around the shared step datapath.
module rv32_mod_muldiv
  import rv32_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        kill_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  func_i,
  input  logic [31:0] read0_data_i,
  input  logic [31:0] read1_data_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] result_o,
  output logic        stall_o
);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d, op_in;
  logic [4:0]    count_q, count_d;
  logic          neg_q, neg_d;
  logic [31:0]   a_q, a_d;       // multiplier / dividend, later quotient
  logic [31:0]   b_q, b_d;       // multiplicand / divisor magnitude
  logic [63:0]   acc_q, acc_d;   // product accumulator / partial remainder
  logic [31:0]   result_q, result_d;

  logic        a_sgn, b_sgn, sign_a, sign_b, neg_in;
  logic [31:0] mag_a, mag_b;
  logic        div0, ovf, special;
  logic [31:0] special_res;
  logic [63:0] step_acc, prod_fix;
  logic        step_qbit;
  logic [31:0] div_word, div_fix, final_res;

  rv32_mod_muldiv_step u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .bit_i    (a_q[31]),
    .opb_i    (b_q),
    .acc_o    (step_acc),
    .qbit_o   (step_qbit)
  );

  // Operand decode at accept: signedness, magnitudes, result sign, special cases.
  always_comb begin
    op_in  = muldiv_op_e'(func_i);
    // MUL is treated as signed x signed so it shares the negate path.
    a_sgn  = op_in inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    b_sgn  = op_in inside {OpMul, OpMulh, OpDiv, OpRem};
    sign_a = a_sgn & read0_data_i[31];
    sign_b = b_sgn & read1_data_i[31];
    mag_a  = sign_a ? (~read0_data_i + 32'd1) : read0_data_i;
    mag_b  = sign_b ? (~read1_data_i + 32'd1) : read1_data_i;
    neg_in = (op_in inside {OpRem, OpRemu}) ? sign_a : (sign_a ^ sign_b);
    div0   = (read1_data_i == 32'd0);
    ovf    = (op_in inside {OpDiv, OpRem}) && (read0_data_i == IntMin) &&
             (read1_data_i == AllOnes);
    special = func_i[2] && (div0 || ovf);
    if (div0) begin
      special_res = func_i[1] ? read0_data_i : AllOnes;
    end else begin
      special_res = func_i[1] ? 32'd0 : IntMin;
    end
  end

  // Final sign fixup and output word selection, valid on the last iteration.
  always_comb begin
    prod_fix  = neg_q ? (~step_acc + 64'd1) : step_acc;
    div_word  = op_q[1] ? step_acc[31:0] : {a_q[30:0], step_qbit};
    div_fix   = neg_q ? (~div_word + 32'd1) : div_word;
    if (op_q[2]) begin
      final_res = div_fix;
    end else if (op_q == OpMul) begin
      final_res = prod_fix[31:0];
    end else begin
      final_res = prod_fix[63:32];
    end
  end

  // Next-state logic; kill overrides everything and returns to idle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i && !kill_i) begin
          op_d    = op_in;
          neg_d   = neg_in;
          a_d     = mag_a;
          b_d     = mag_b;
          acc_d   = '0;
          count_d = '0;
          if (special) begin
            result_d = special_res;
            state_d  = StDone;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        acc_d   = step_acc;
        a_d     = {a_q[30:0], step_qbit};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          result_d = final_res;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (kill_i) state_d = StIdle;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      count_q  <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle);
  assign stall_o      = (state_q != StIdle);
  assign resp_valid_o = (state_q == StDone);
  assign result_o     = result_q;

endmodule
